// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder signal source: a phase accumulator paces A/B/Z steps, and frequency/direction are reloaded over valid/ready.
// Define QENC_POS_OUT_EN to add the signed edge-position output pos (absent in the default build).
module quad_encoder_emulator #(
  parameter int CLK_HZ = 50_000_000,
  parameter int ACC_W  = 32,
  parameter int CPR    = 1000,
  parameter int POS_W  = 32
) (
  input  logic             CLOCK_50M,
  input  logic             RST,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_ftw,
  input  logic             cfg_dir,
  output logic             enc_a,
  output logic             enc_b,
  output logic             enc_z,
  output logic             index_tick
`ifdef QENC_POS_OUT_EN
  ,
  output logic [POS_W-1:0] pos
`endif
);
  localparam int                EDGE_W    = $clog2(4 * CPR);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(4 * CPR - 1);

  // State encoding is the {A,B} output pair itself.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b10,
    S2 = 2'b11,
    S3 = 2'b01
  } quad_e;

  if (CLK_HZ < 1 || ACC_W < 2 || CPR < 1 || POS_W < 2) begin : g_param_check
    $error("quad_encoder_emulator: invalid parameter set");
  end

  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  ftw_act_q;
  logic [ACC_W-1:0]  pend_ftw_q;
  logic              carry_q;
  logic              dir_act_q;
  logic              pend_dir_q;
  logic              pending_q;
  logic              cfg_ready_q;
  logic              enc_z_q;
  logic              index_tick_q;
  logic [EDGE_W-1:0] edge_cnt_q;
  quad_e             state_q;
`ifdef QENC_POS_OUT_EN
  logic [POS_W-1:0]  pos_q;
`endif

  logic              idle_s;
  logic              accept_s;
  logic              step_s;
  logic              apply_s;
  logic              step_dir_s;
  logic [ACC_W:0]    sum_s;
  logic [EDGE_W-1:0] edge_cnt_d;

  function automatic quad_e quad_next(input quad_e cur, input logic rev);
    case (cur)
      S0:      quad_next = rev ? S3 : S1;
      S1:      quad_next = rev ? S0 : S2;
      S2:      quad_next = rev ? S1 : S3;
      S3:      quad_next = rev ? S2 : S0;
      default: quad_next = S0;
    endcase
  endfunction

  // Step/apply decisions; a pending config applied on a step already steers that step.
  always_comb begin
    idle_s     = (ftw_act_q == '0);
    accept_s   = cfg_valid & cfg_ready_q;
    sum_s      = {1'b0, acc_q} + {1'b0, ftw_act_q};
    step_s     = carry_q & ~idle_s;
    apply_s    = pending_q & (idle_s | step_s);
    step_dir_s = pending_q ? pend_dir_q : dir_act_q;
    if (step_dir_s) begin
      if (edge_cnt_q == '0) begin
        edge_cnt_d = EDGE_LAST;
      end else begin
        edge_cnt_d = edge_cnt_q - EDGE_W'(1);
      end
    end else begin
      if (edge_cnt_q == EDGE_LAST) begin
        edge_cnt_d = '0;
      end else begin
        edge_cnt_d = edge_cnt_q + EDGE_W'(1);
      end
    end
  end

  // Accumulator, config handshake and quadrature state machine.
  always_ff @(posedge CLOCK_50M) begin
    if (RST) begin
      acc_q        <= '0;
      carry_q      <= 1'b0;
      ftw_act_q    <= '0;
      dir_act_q    <= 1'b0;
      pend_ftw_q   <= '0;
      pend_dir_q   <= 1'b0;
      pending_q    <= 1'b0;
      cfg_ready_q  <= 1'b1;
      state_q      <= S0;
      edge_cnt_q   <= '0;
      enc_z_q      <= 1'b0;
      index_tick_q <= 1'b0;
`ifdef QENC_POS_OUT_EN
      pos_q        <= '0;
`endif
    end else begin
      // Leaving the stopped state restarts the phase from zero.
      if (apply_s && idle_s) begin
        acc_q   <= '0;
        carry_q <= 1'b0;
      end else begin
        acc_q   <= sum_s[ACC_W-1:0];
        carry_q <= sum_s[ACC_W];
      end

      if (apply_s) begin
        ftw_act_q   <= pend_ftw_q;
        dir_act_q   <= pend_dir_q;
        pending_q   <= 1'b0;
        cfg_ready_q <= 1'b1;
      end else if (accept_s) begin
        pend_ftw_q  <= cfg_ftw;
        pend_dir_q  <= cfg_dir;
        pending_q   <= 1'b1;
        cfg_ready_q <= 1'b0;
      end else begin
        pending_q   <= pending_q;
        cfg_ready_q <= cfg_ready_q;
      end

      if (step_s) begin
        state_q      <= quad_next(state_q, step_dir_s);
        edge_cnt_q   <= edge_cnt_d;
        enc_z_q      <= (edge_cnt_d == '0);
        index_tick_q <= (edge_cnt_d == '0) & ~enc_z_q;
`ifdef QENC_POS_OUT_EN
        pos_q        <= step_dir_s ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
`endif
      end else begin
        index_tick_q <= 1'b0;
      end
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign enc_a      = state_q[1];
  assign enc_b      = state_q[0];
  assign enc_z      = enc_z_q;
  assign index_tick = index_tick_q;
`ifdef QENC_POS_OUT_EN
  assign pos        = pos_q;
`endif

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Scoreboard bench for quad_encoder_emulator: an integer-position reference model predicts every cycle's outputs.
module tb_quad_encoder_emulator;
  localparam int     ACC_W   = 32;
  localparam int     CPR     = 4;
  localparam int     POS_W   = 32;
  localparam int     EDGES   = 4 * CPR;
  localparam longint ACC_MOD = 64'd1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic [ACC_W-1:0] cfg_ftw = '0;
  logic             cfg_dir = 1'b0;
  logic             cfg_ready;
  logic             enc_a;
  logic             enc_b;
  logic             enc_z;
  logic             index_tick;
`ifdef QENC_POS_OUT_EN
  logic [POS_W-1:0] pos;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  quad_encoder_emulator #(
    .CLK_HZ(50_000_000),
    .ACC_W (ACC_W),
    .CPR   (CPR),
    .POS_W (POS_W)
  ) dut (
    .CLOCK_50M (clk),
    .RST       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ftw   (cfg_ftw),
    .cfg_dir   (cfg_dir),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .enc_z     (enc_z),
    .index_tick(index_tick)
`ifdef QENC_POS_OUT_EN
    ,
    .pos       (pos)
`endif
  );

  typedef struct packed {
    logic             a;
    logic             b;
    logic             z;
    logic             tick;
    logic             ready;
    logic [POS_W-1:0] pos;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int wrapmod(input longint v, input int m);
    longint r;
    r = v % m;
    if (r < 0) r = r + m;
    return int'(r);
  endfunction

  // Reference model: position is a plain signed integer; A/B come from position mod 4.
  longint m_phase = 0;
  bit     m_wrap  = 1'b0;
  longint m_ftw   = 0;
  bit     m_dir   = 1'b0;
  bit     m_pend  = 1'b0;
  longint m_pftw  = 0;
  bit     m_pdir  = 1'b0;
  bit     m_ready = 1'b1;
  longint m_pos   = 0;
  bit     m_z     = 1'b0;
  bit     m_tick  = 1'b0;

  always @(posedge clk) begin
    exp_t   e;
    bit     step;
    bit     apply;
    bit     sdir;
    longint total;
    int     q;
    if (rst) begin
      m_phase = 0; m_wrap = 1'b0; m_ftw = 0; m_dir = 1'b0; m_pend = 1'b0;
      m_pftw = 0; m_pdir = 1'b0; m_ready = 1'b1; m_pos = 0; m_z = 1'b0; m_tick = 1'b0;
    end else begin
      step   = m_wrap && (m_ftw != 0);
      apply  = m_pend && ((m_ftw == 0) || step);
      sdir   = m_pend ? m_pdir : m_dir;
      m_tick = 1'b0;
      if (step) begin
        m_pos = m_pos + (sdir ? -1 : 1);
        if (wrapmod(m_pos, EDGES) == 0) begin
          m_tick = !m_z;
          m_z    = 1'b1;
        end else begin
          m_z    = 1'b0;
        end
      end
      if (apply && (m_ftw == 0)) begin
        m_phase = 0;
        m_wrap  = 1'b0;
      end else begin
        total   = m_phase + m_ftw;
        m_wrap  = (total >= ACC_MOD);
        m_phase = total % ACC_MOD;
      end
      if (apply) begin
        m_ftw = m_pftw; m_dir = m_pdir; m_pend = 1'b0; m_ready = 1'b1;
      end else if (cfg_valid && m_ready) begin
        m_pftw = longint'(cfg_ftw); m_pdir = cfg_dir; m_pend = 1'b1; m_ready = 1'b0;
      end
    end
    q       = wrapmod(m_pos, 4);
    e.a     = (q == 1) || (q == 2);
    e.b     = (q == 2) || (q == 3);
    e.z     = m_z;
    e.tick  = m_tick;
    e.ready = m_ready;
    e.pos   = m_pos[POS_W-1:0];
    exp_q.push_back(e);
  end

  // Monitor: compares DUT outputs against the queued prediction away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("enc_a", enc_a, e.a);
      chk("enc_b", enc_b, e.b);
      chk("enc_z", enc_z, e.z);
      chk("index_tick", index_tick, e.tick);
      chk("cfg_ready", cfg_ready, e.ready);
`ifdef QENC_POS_OUT_EN
      chk("pos", pos, e.pos);
`endif
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [ACC_W-1:0] ftw, input logic dir);
    int waited;
    waited    = 0;
    cfg_valid = 1'b1;
    cfg_ftw   = ftw;
    cfg_dir   = dir;
    while (cfg_ready !== 1'b1 && waited < 2000) begin
      cycles(1);
      waited++;
    end
    if (waited >= 2000) begin
      chk("cfg_accept_timeout", 64'd1, 64'd0);
    end else begin
      cycles(1);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
  endtask

  initial begin
    int          a_rises;
    int          ticks;
    logic        prev_a;
    int          r;
    logic [31:0] ftw;

    cycles(3);
    rst = 1'b0;
    cycles(2);

    // Forward at quarter rate, then directed period/index counts over three revolutions.
    send_cfg(32'h4000_0000, 1'b0);
    cycles(20);
    a_rises = 0;
    ticks   = 0;
    prev_a  = enc_a;
    for (int i = 0; i < 192; i++) begin
      cycles(1);
      if (enc_a && !prev_a) a_rises++;
      if (index_tick) ticks++;
      prev_a = enc_a;
    end
    chk("enc_a_rises_in_192", a_rises, 12);
    chk("index_ticks_in_192", ticks, 3);

    // Reverse, stop, resume at half rate.
    send_cfg(32'h4000_0000, 1'b1);
    cycles(100);
    send_cfg(32'h0000_0000, 1'b0);
    cycles(1000);
    send_cfg(32'h8000_0000, 1'b0);
    cycles(50);

    // Back-to-back configs: the second stalls until the first is applied.
    send_cfg(32'h4000_0000, 1'b1);
    send_cfg(32'h2000_0000, 1'b0);
    cycles(80);

    // Reset mid-run: no stepping until a new config is accepted.
    pulse_reset();
    cycles(30);

    for (int it = 0; it < 30; it++) begin
      r = int'($urandom_range(9, 0));
      if (r == 0) begin
        ftw = 32'h0000_0000;
      end else if (r == 1) begin
        ftw = 32'hFFFF_FFFF;
      end else begin
        ftw = $urandom_range(32'hFFFF_FFFF, 32'h0100_0000);
      end
      send_cfg(ftw, 1'($urandom_range(1, 0)));
      cycles(int'($urandom_range(120, 0)));
      if (r == 2) pulse_reset();
    end

    cycles(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
